// File: rtl/minmax_frame_seq_if.sv
// minmax_frame_seq_if: sample input and frame-result handshakes for minmax_frame_seq.
interface minmax_frame_seq_if #(
  parameter int BIT_WIDTH = 16,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
);
  logic [BIT_WIDTH-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 flush;
  logic [BIT_WIDTH-1:0] out_min;
  logic [BIT_WIDTH-1:0] out_max;
  logic [CNT_W-1:0]     out_count;
  logic                 out_valid;
  logic                 out_ready;
  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_min, out_max, out_count, out_valid
  );
  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_min, out_max, out_count, out_valid
  );
endinterface

// File: rtl/minmax_frame_seq.sv
// minmax_frame_seq: serial unsigned min/max/count over a frame, result held until accepted.
module minmax_frame_seq #(
  parameter int BIT_WIDTH = 16,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input logic           clk,
  input logic           rst_n,
  minmax_frame_seq_if.slave s
);
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [BIT_WIDTH-1:0] min_q, min_d, max_q, max_d;
  logic [BIT_WIDTH-1:0] omin_q, omin_d, omax_q, omax_d;
  logic [CNT_W-1:0]     ocnt_q, ocnt_d;
  logic                 ovalid_q, ovalid_d;
  logic                 acc, close, release_res;
  assign s.in_ready  = rst_n && (state_q == COLLECT);
  assign s.out_min   = omin_q;
  assign s.out_max   = omax_q;
  assign s.out_count = ocnt_q;
  assign s.out_valid = ovalid_q;
  always_comb begin
    acc         = s.in_valid && s.in_ready;
    cnt_inc     = cnt_q + CNT_W'(1);
    release_res = (state_q == HOLD) && s.out_ready;
    // a flush closes the frame only if it would contain at least one sample
    close       = (state_q == COLLECT) &&
                  ((acc && cnt_inc == CNT_W'(FRAME_LEN)) || (s.flush && (cnt_q != '0 || acc)));
    min_d       = acc && (cnt_q == '0 || s.in_data < min_q) ? s.in_data : min_q;
    max_d       = acc && (cnt_q == '0 || s.in_data > max_q) ? s.in_data : max_q;
    cnt_d       = acc ? cnt_inc : release_res ? '0 : cnt_q;
    state_d     = close ? HOLD : release_res ? COLLECT : state_q;
    omin_d      = close ? min_d : omin_q;
    omax_d      = close ? max_d : omax_q;
    ocnt_d      = close ? cnt_d : ocnt_q;
    ovalid_d    = close ? 1'b1 : release_res ? 1'b0 : ovalid_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      min_q    <= '0;
      max_q    <= '0;
      omin_q   <= '0;
      omax_q   <= '0;
      ocnt_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      min_q    <= min_d;
      max_q    <= max_d;
      omin_q   <= omin_d;
      omax_q   <= omax_d;
      ocnt_q   <= ocnt_d;
      ovalid_q <= ovalid_d;
    end
  end
endmodule

// File: tb/tb_minmax_frame_seq.sv
// tb_minmax_frame_seq: scenario tasks plus a result scoreboard fed by a behavioural model.
module tb_minmax_frame_seq;
  logic clk = 0;
  logic rst_n = 0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  minmax_frame_seq_if #(.BIT_WIDTH(16), .FRAME_LEN(8)) bus ();
  minmax_frame_seq #(.BIT_WIDTH(16), .FRAME_LEN(8)) dut (.clk(clk), .rst_n(rst_n), .s(bus));
  typedef struct {logic [15:0] mn; logic [15:0] mx; int cnt;} res_t;
  res_t exp_q[$];
  res_t mon_r;
  bit m_hold = 0;
  int m_cnt = 0;
  logic [15:0] m_min = 0, m_max = 0;
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard: unexpected result min=%0h max=%0h cnt=%0d", bus.out_min, bus.out_max, bus.out_count);
      end else begin
        mon_r = exp_q.pop_front();
        if (bus.out_min !== mon_r.mn || bus.out_max !== mon_r.mx || bus.out_count !== 4'(mon_r.cnt)) begin
          fails++;
          $display("FAIL scoreboard: got min=%0h max=%0h cnt=%0d, expected min=%0h max=%0h cnt=%0d",
                   bus.out_min, bus.out_max, bus.out_count, mon_r.mn, mon_r.mx, mon_r.cnt);
        end
      end
    end
  end
  task automatic step(output bit acc);
    acc = bus.in_valid && !m_hold && rst_n;
    if (!rst_n) begin
      m_hold = 0; m_cnt = 0; exp_q.delete();
    end else if (!m_hold) begin
      if (acc) begin
        m_min = (m_cnt == 0 || bus.in_data < m_min) ? bus.in_data : m_min;
        m_max = (m_cnt == 0 || bus.in_data > m_max) ? bus.in_data : m_max;
        m_cnt++;
      end
      if ((acc && m_cnt == 8) || (bus.flush && m_cnt > 0)) begin
        exp_q.push_back('{m_min, m_max, m_cnt});
        m_hold = 1;
      end
    end else if (bus.out_ready) begin
      m_hold = 0; m_cnt = 0;
    end
    @(posedge clk); #1;
  endtask
  task automatic drain();
    bit a;
    bus.in_valid = 0; bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      bus.flush = (m_cnt > 0 && !m_hold);
      step(a);
    end
    bus.flush = 0;
  endtask
  task automatic test_reset();
    bit a;
    rst_n = 0;
    step(a);
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    tests++; if (bus.out_min !== 16'h0 || bus.out_max !== 16'h0) begin fails++; $display("FAIL reset_minmax: got %0h/%0h want 0/0", bus.out_min, bus.out_max); end
    tests++; if (bus.out_count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", bus.out_count); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    rst_n = 1;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
  endtask
  task automatic test_frame();
    logic [15:0] smp [8] = '{16'd5, 16'd3, 16'd9, 16'd3, 16'd12, 16'd0, 16'd7, 16'd12};
    int idx = 0, first = -1, second = -1;
    bit a, prev = 0;
    bus.out_ready = 1;
    for (int c = 0; c < 40 && idx < 16; c++) begin
      bus.in_valid = 1; bus.in_data = smp[idx % 8];
      step(a);
      if (a) idx++;
      if (a && idx == 8) begin
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_min !== 16'd0 || bus.out_max !== 16'd12 || bus.out_count !== 4'd8) begin
          fails++; $display("FAIL frame_result: got v=%b min=%0d max=%0d cnt=%0d want 1/0/12/8", bus.out_valid, bus.out_min, bus.out_max, bus.out_count);
        end
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL frame_hold_in_ready: got %b want 0", bus.in_ready); end
      end
      if (bus.out_valid && !prev) begin
        if (first < 0) first = c; else second = c;
      end
      prev = bus.out_valid;
    end
    tests++; if (second - first !== 9) begin fails++; $display("FAIL frame_period: got %0d want 9", second - first); end
    drain();
  endtask
  task automatic test_backpressure();
    bit a;
    bus.out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1; bus.in_data = 16'(i * 3 + 1);
      step(a);
    end
    bus.in_data = 16'd77;
    for (int i = 0; i < 10; i++) begin
      step(a);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_min !== 16'd1 || bus.out_max !== 16'd22 || bus.out_count !== 4'd8 || bus.in_ready !== 1'b0) begin
        fails++; $display("FAIL bp_stall%0d: got v=%b min=%0d max=%0d cnt=%0d rdy=%b want 1/1/22/8/0", i, bus.out_valid, bus.out_min, bus.out_max, bus.out_count, bus.in_ready);
      end
    end
    bus.out_ready = 1;
    step(a);
    tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_release: got rdy=%b v=%b want 1/0", bus.in_ready, bus.out_valid); end
    step(a);
    bus.in_valid = 0; bus.flush = 1;
    step(a);
    bus.flush = 0;
    tests++; if (bus.out_count !== 4'd1 || bus.out_min !== 16'd77 || bus.out_max !== 16'd77) begin fails++; $display("FAIL bp_consumed: got cnt=%0d min=%0d max=%0d want 1/77/77", bus.out_count, bus.out_min, bus.out_max); end
    drain();
  endtask
  task automatic test_flush();
    logic [15:0] smp [3] = '{16'hFFFF, 16'h0001, 16'h8000};
    bit a;
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1; bus.in_data = smp[i];
      step(a);
    end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL flush_early: got v=%b want 0", bus.out_valid); end
    bus.in_valid = 0; bus.flush = 1;
    step(a);
    bus.flush = 0;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_min !== 16'h0001 || bus.out_max !== 16'hFFFF || bus.out_count !== 4'd3) begin
      fails++; $display("FAIL flush_result: got v=%b min=%0h max=%0h cnt=%0d want 1/1/ffff/3", bus.out_valid, bus.out_min, bus.out_max, bus.out_count);
    end
    bus.out_ready = 1;
    step(a);
    bus.flush = 1;
    for (int i = 0; i < 3; i++) begin
      step(a);
      tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL flush_empty%0d: got v=%b rdy=%b want 0/1", i, bus.out_valid, bus.in_ready); end
    end
    bus.flush = 0;
    drain();
  endtask
  task automatic test_flush_with_sample();
    bit a;
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_data = 16'd100;
    step(a);
    bus.in_data = 16'd40; bus.flush = 1;
    step(a);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_min !== 16'd40 || bus.out_max !== 16'd100 || bus.out_count !== 4'd2) begin
      fails++; $display("FAIL flush_sample: got v=%b min=%0d max=%0d cnt=%0d want 1/40/100/2", bus.out_valid, bus.out_min, bus.out_max, bus.out_count);
    end
    bus.in_data = 16'd1;
    for (int i = 0; i < 3; i++) begin
      step(a);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_min !== 16'd40 || bus.out_count !== 4'd2 || bus.in_ready !== 1'b0) begin
        fails++; $display("FAIL flush_in_hold%0d: got v=%b min=%0d cnt=%0d rdy=%b want 1/40/2/0", i, bus.out_valid, bus.out_min, bus.out_count, bus.in_ready);
      end
    end
    bus.flush = 0;
    drain();
  endtask
  task automatic test_gapped();
    bit a;
    bus.out_ready = 0;
    bus.in_data = 16'h1234;
    for (int i = 0; i < 15; i++) begin
      bus.in_valid = (i % 2 == 0);
      step(a);
    end
    bus.in_valid = 0;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_min !== 16'h1234 || bus.out_max !== 16'h1234 || bus.out_count !== 4'd8) begin
      fails++; $display("FAIL gapped: got v=%b min=%0h max=%0h cnt=%0d want 1/1234/1234/8", bus.out_valid, bus.out_min, bus.out_max, bus.out_count);
    end
    drain();
  endtask
  task automatic test_reset_mid_frame();
    bit a;
    bus.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1; bus.in_data = 16'(50 + i);
      step(a);
    end
    bus.in_valid = 0; rst_n = 0;
    step(a);
    rst_n = 1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_min !== 16'h0 || bus.out_max !== 16'h0 || bus.out_count !== 4'd0) begin
      fails++; $display("FAIL midreset: got v=%b min=%0h max=%0h cnt=%0d want 0/0/0/0", bus.out_valid, bus.out_min, bus.out_max, bus.out_count);
    end
    bus.out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1; bus.in_data = 16'(200 - i * 10);
      step(a);
      if (i == 5) begin
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL midreset_early: got v=%b want 0", bus.out_valid); end
      end
    end
    bus.in_valid = 0;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_min !== 16'd130 || bus.out_max !== 16'd200 || bus.out_count !== 4'd8) begin
      fails++; $display("FAIL midreset_frame: got v=%b min=%0d max=%0d cnt=%0d want 1/130/200/8", bus.out_valid, bus.out_min, bus.out_max, bus.out_count);
    end
    drain();
  endtask
  initial begin
    bus.in_valid = 0; bus.in_data = 0; bus.flush = 0; bus.out_ready = 0;
    test_reset();
    test_frame();
    test_backpressure();
    test_flush();
    test_flush_with_sample();
    test_gapped();
    test_reset_mid_frame();
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/minmax_frame_seq.md
# minmax_frame_seq

Sequential frame-based min/max tracker for sensor sample streams, such as line-sensor or encoder readings. It accepts samples one per cycle over a valid/ready handshake and reuses a single compare stage across a frame of FRAME_LEN samples. It then presents the frame's unsigned minimum, maximum and sample count on a held output handshake. The block sits between a sensor sampler and calibration/threshold logic, replacing a wide parallel min/max tree when samples arrive serially.

## Interface
- BIT_WIDTH, 16, sample width in bits.
- FRAME_LEN, 8, samples per full frame; legal range 1..65535.
- CNT_W, $clog2(FRAME_LEN+1), width of the sample counter and out_count (derived; do not override).
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- in_data  input  BIT_WIDTH  sample, unsigned.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a sample this cycle.
- flush  input  1  close the current frame early (partial frame).
- out_min  output  BIT_WIDTH  frame minimum.
- out_max  output  BIT_WIDTH  frame maximum.
- out_count  output  CNT_W  samples in the reported frame (1..FRAME_LEN).
- out_valid  output  1  out_min/out_max/out_count valid.
- out_ready  input  1  consumer accepts the result.

## Operation
- Two states: COLLECT and HOLD. Reset enters COLLECT with the counter at 0.
- in_ready = 1 in COLLECT, 0 in HOLD; in_ready = 0 while rst_n is low.
- A sample is accepted on a cycle with in_valid && in_ready.
- Accepted sample with count == 0: min = max = in_data.
- Accepted sample with count > 0:
  - min <= (in_data < min) ? in_data : min
  - max <= (in_data > max) ? in_data : max
  - Comparisons are strict and unsigned, so on ties the register keeps its old value.
- Each accepted sample increments the counter.
- Frame close, COLLECT -> HOLD, happens on either:
  - an accepted sample that brings the count to FRAME_LEN; or
  - flush = 1 while count > 0 (with or without a sample that cycle).
- Flush with a simultaneous accepted sample: the sample is included, then the frame closes.
- Flush with count == 0 and no accepted sample: ignored, stays in COLLECT.
- Flush with count == 0 and an accepted sample: closes a 1-sample frame.
- On close: out_min/out_max/out_count load the final values and out_valid = 1.
- HOLD: outputs are stable and flush is ignored. When out_ready = 1, the block returns to COLLECT, counter = 0, out_valid = 0.
- out_min/out_max/out_count keep their last values after the handshake until the next close.
- Working min/max registers are internal; outputs never show a partial frame.
- Counter never exceeds FRAME_LEN, so no wrap-around.

## Timing
- Reset values, asserted on the first rising edge with rst_n = 0: state COLLECT, count 0, out_min 0, out_max 0, out_count 0, out_valid 0.
- Latency: out_valid rises on the cycle after the closing sample or flush is sampled.
- The result handshake completes on a clock edge where out_valid && out_ready. in_ready is 1 on the following cycle.
- out_ready held high: minimum period FRAME_LEN+1 cycles per frame, because HOLD lasts at least one cycle and no sample is accepted in HOLD.
- out_ready low: the block stalls indefinitely in HOLD; in_ready stays 0 and upstream must hold its data.
- in_valid may drop at any time in COLLECT; the partial frame is retained, with no timeout.
- Reset mid-frame or in HOLD discards all state and any pending result. out_valid is 0 on the next cycle.
- All outputs are registered except in_ready, which decodes state and rst_n only.

## Test plan
- Reset mid-frame: after 3 samples assert rst_n = 0 for 1 cycle -> out_valid 0, outputs 0; the next frame of 8 samples is counted from 0.
- FRAME_LEN = 8, continuous in_valid, out_ready = 1, samples 5,3,9,3,12,0,7,12 -> one cycle after the 8th sample: out_min 0, out_max 12, out_count 8; period 9 cycles across back-to-back frames.
- Backpressure: out_ready low for 10 cycles after close -> out_valid stays 1, outputs stable, in_ready 0, no sample consumed; sample accepted the cycle after out_ready = 1.
- Flush with 3 samples 0xFFFF,0x0001,0x8000, flush on the cycle after the 3rd -> out_min 0x0001, out_max 0xFFFF, out_count 3. Flush at count 0 with no sample -> no out_valid.
- Flush with simultaneous 2nd sample (100 then 40 with flush) -> out_min 40, out_max 100, out_count 2. Flush asserted in HOLD -> no effect.
- Gapped input: in_valid toggling every other cycle, all samples 0x1234 -> out_min = out_max = 0x1234, out_count 8.
